// File: rtl/pcie_rq_arbiter.sv
// Packet-level two-input arbiter for the PCIe RQ AXI-stream.
// Port 1 (ATS invalidation completions) has priority. A burst counter
// forces a port-0 grant after MAX_P1_BURST port-1 packets while port 0 waits.
module pcie_rq_arbiter #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int RQ_AXIS_TUSER_W = 183,
  parameter int MAX_P1_BURST    = 4
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [RQ_AXIS_TUSER_W-1:0]   s0_axis_tuser,
  input  logic                         s0_axis_tlast,
  input  logic                         s0_axis_tvalid,
  output logic                         s0_axis_tready,

  input  logic [AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [RQ_AXIS_TUSER_W-1:0]   s1_axis_tuser,
  input  logic                         s1_axis_tlast,
  input  logic                         s1_axis_tvalid,
  output logic                         s1_axis_tready,

  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [RQ_AXIS_TUSER_W-1:0]   m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,

  output logic [1:0]                   grant,
  output logic [15:0]                  p0_pkt_cnt,
  output logic [15:0]                  p1_pkt_cnt
);

  // Encoding doubles as the one-hot grant vector, so grant is a flop output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] p0_cnt_q, p1_cnt_q;
  logic        p0_done, p1_done, burst_full;

  assign burst_full = (burst_q == 8'(MAX_P1_BURST));
  assign grant      = state_q;
  assign p0_pkt_cnt = p0_cnt_q;
  assign p1_pkt_cnt = p1_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
    end else begin
      if (p0_done) p0_cnt_q <= p0_cnt_q + 16'd1;
      if (p1_done) p1_cnt_q <= p1_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    burst_d        = burst_q;
    p0_done        = 1'b0;
    p1_done        = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s1_axis_tvalid && !(s0_axis_tvalid && burst_full)) state_d = GNT1;
        else if (s0_axis_tvalid)                                state_d = GNT0;
      end
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
        p0_done        = s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
        if (p0_done) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
        p1_done        = s1_axis_tvalid & m_axis_tready & s1_axis_tlast;
        if (p1_done) begin
          state_d = IDLE;
          if (!s0_axis_tvalid) burst_d = '0;
          else if (!burst_full) burst_d = burst_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Directed bench for pcie_rq_arbiter with MAX_P1_BURST = 4.
module tb_pcie_rq_arbiter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 183;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
  logic          s0_tlast, s0_tvalid, s0_tready;
  logic          s1_tlast, s1_tvalid, s1_tready;
  logic          m_tlast, m_tvalid, m_tready;
  logic [1:0]    grant;
  logic [15:0]   p0_cnt, p1_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pcie_rq_arbiter #(
    .AXIS_DATA_WIDTH(DW),
    .RQ_AXIS_TUSER_W(UW),
    .MAX_P1_BURST   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s0_axis_tdata (s0_tdata),
    .s0_axis_tkeep (s0_tkeep),
    .s0_axis_tuser (s0_tuser),
    .s0_axis_tlast (s0_tlast),
    .s0_axis_tvalid(s0_tvalid),
    .s0_axis_tready(s0_tready),
    .s1_axis_tdata (s1_tdata),
    .s1_axis_tkeep (s1_tkeep),
    .s1_axis_tuser (s1_tuser),
    .s1_axis_tlast (s1_tlast),
    .s1_axis_tvalid(s1_tvalid),
    .s1_axis_tready(s1_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant         (grant),
    .p0_pkt_cnt    (p0_cnt),
    .p1_pkt_cnt    (p1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drv0(input logic v, input logic [15:0] d, input logic l);
    s0_tvalid = v;
    s0_tdata  = '0;
    s0_tdata[15:0] = d;
    s0_tlast  = l;
  endtask

  task automatic drv1(input logic v, input logic [15:0] d, input logic l);
    s1_tvalid = v;
    s1_tdata  = '0;
    s1_tdata[15:0] = d;
    s1_tlast  = l;
  endtask

  logic [1:0] exp_order [10];

  initial begin
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    rst      = 1'b0;
    m_tready = 1'b1;
    s0_tkeep = '1;
    s1_tkeep = {KW/2{2'b01}};
    s0_tuser = '0;
    s0_tuser[7:0] = 8'h5A;
    s1_tuser = '0;
    s1_tuser[7:0] = 8'hC3;
    drv0(1'b0, 16'h0, 1'b0);
    drv1(1'b0, 16'h0, 1'b0);

    // reset state
    repeat (3) look();
    chk("rst_grant", DW'(grant), DW'(2'b00));
    chk("rst_mvalid", DW'(m_tvalid), DW'(1'b0));
    chk("rst_s0rdy", DW'(s0_tready), DW'(1'b0));
    chk("rst_s1rdy", DW'(s1_tready), DW'(1'b0));
    chk("rst_p0cnt", DW'(p0_cnt), DW'(16'd0));
    chk("rst_p1cnt", DW'(p1_cnt), DW'(16'd0));
    rst = 1'b1;
    cyc(); look();
    chk("idle_grant", DW'(grant), DW'(2'b00));
    chk("idle_mvalid", DW'(m_tvalid), DW'(1'b0));

    // port 0 alone, 3-beat TLP
    cyc();
    drv0(1'b1, 16'hA001, 1'b0);
    look();
    chk("p0_c0_grant", DW'(grant), DW'(2'b00));
    chk("p0_c0_s0rdy", DW'(s0_tready), DW'(1'b0));
    cyc(); look();
    chk("p0_c1_grant", DW'(grant), DW'(2'b01));
    chk("p0_c1_data", m_tdata, DW'(16'hA001));
    chk("p0_c1_keep", DW'(m_tkeep), DW'(s0_tkeep));
    chk("p0_c1_user", DW'(m_tuser), DW'(8'h5A));
    chk("p0_c1_s0rdy", DW'(s0_tready), DW'(1'b1));
    cyc();
    drv0(1'b1, 16'hA002, 1'b0);
    look();
    chk("p0_c2_data", m_tdata, DW'(16'hA002));
    cyc();
    drv0(1'b1, 16'hA003, 1'b1);
    look();
    chk("p0_c3_data", m_tdata, DW'(16'hA003));
    chk("p0_c3_last", DW'(m_tlast), DW'(1'b1));
    cyc();
    drv0(1'b0, 16'h0, 1'b0);
    look();
    chk("p0_c4_grant", DW'(grant), DW'(2'b00));
    chk("p0_c4_data", m_tdata, DW'(0));
    chk("p0_c4_p0cnt", DW'(p0_cnt), DW'(16'd1));

    // both ports valid, single-beat TLPs, starvation guard
    cyc();
    drv0(1'b1, 16'hB000, 1'b1);
    drv1(1'b1, 16'hC000, 1'b1);
    look();
    for (int k = 0; k < 10; k++) begin
      cyc(); look();
      chk($sformatf("burst_grant%0d", k), DW'(grant), DW'(exp_order[k]));
      chk($sformatf("burst_data%0d", k), m_tdata,
          (exp_order[k] == 2'b01) ? DW'(16'hB000) : DW'(16'hC000));
      cyc(); look();
      chk($sformatf("burst_gap%0d", k), DW'(grant), DW'(2'b00));
    end
    drv0(1'b0, 16'h0, 1'b0);
    drv1(1'b0, 16'h0, 1'b0);
    chk("burst_p0cnt", DW'(p0_cnt), DW'(16'd3));
    chk("burst_p1cnt", DW'(p1_cnt), DW'(16'd8));

    // port 1 arrives while port 0 is mid-packet
    cyc();
    drv0(1'b1, 16'hD001, 1'b0);
    cyc();
    cyc();
    drv0(1'b1, 16'hD002, 1'b0);
    drv1(1'b1, 16'hE001, 1'b1);
    look();
    chk("mid_b2_grant", DW'(grant), DW'(2'b01));
    chk("mid_b2_data", m_tdata, DW'(16'hD002));
    chk("mid_b2_s1rdy", DW'(s1_tready), DW'(1'b0));
    cyc();
    drv0(1'b1, 16'hD003, 1'b0);
    look();
    chk("mid_b3_s1rdy", DW'(s1_tready), DW'(1'b0));
    chk("mid_b3_data", m_tdata, DW'(16'hD003));
    cyc();
    drv0(1'b1, 16'hD004, 1'b1);
    look();
    chk("mid_b4_data", m_tdata, DW'(16'hD004));
    chk("mid_b4_s1rdy", DW'(s1_tready), DW'(1'b0));
    cyc();
    drv0(1'b0, 16'h0, 1'b0);
    look();
    chk("mid_gap_grant", DW'(grant), DW'(2'b00));
    chk("mid_gap_s1rdy", DW'(s1_tready), DW'(1'b0));
    chk("mid_p0cnt", DW'(p0_cnt), DW'(16'd4));
    cyc(); look();
    chk("mid_p1_grant", DW'(grant), DW'(2'b10));
    chk("mid_p1_data", m_tdata, DW'(16'hE001));
    chk("mid_p1_s1rdy", DW'(s1_tready), DW'(1'b1));
    chk("mid_p1_keep", DW'(m_tkeep), DW'(s1_tkeep));
    cyc();
    drv1(1'b0, 16'h0, 1'b0);
    look();
    chk("mid_end_grant", DW'(grant), DW'(2'b00));
    chk("mid_p1cnt", DW'(p1_cnt), DW'(16'd9));

    // m_axis_tready toggling 1,0,0,1
    cyc();
    drv0(1'b1, 16'hF001, 1'b0);
    cyc(); look();
    chk("bp_c1_data", m_tdata, DW'(16'hF001));
    chk("bp_c1_s0rdy", DW'(s0_tready), DW'(1'b1));
    cyc();
    drv0(1'b1, 16'hF002, 1'b1);
    m_tready = 1'b0;
    look();
    chk("bp_c2_data", m_tdata, DW'(16'hF002));
    chk("bp_c2_s0rdy", DW'(s0_tready), DW'(1'b0));
    chk("bp_c2_mvalid", DW'(m_tvalid), DW'(1'b1));
    cyc(); look();
    chk("bp_c3_grant", DW'(grant), DW'(2'b01));
    chk("bp_c3_data", m_tdata, DW'(16'hF002));
    chk("bp_c3_last", DW'(m_tlast), DW'(1'b1));
    chk("bp_c3_p0cnt", DW'(p0_cnt), DW'(16'd4));
    cyc();
    m_tready = 1'b1;
    look();
    chk("bp_c4_data", m_tdata, DW'(16'hF002));
    chk("bp_c4_s0rdy", DW'(s0_tready), DW'(1'b1));
    cyc();
    drv0(1'b0, 16'h0, 1'b0);
    look();
    chk("bp_end_grant", DW'(grant), DW'(2'b00));
    chk("bp_p0cnt", DW'(p0_cnt), DW'(16'd5));

    // port-1 counter wrap from a preloaded 0xFFFF
    force dut.p1_cnt_q = 16'hFFFF;
    #1;
    release dut.p1_cnt_q;
    cyc();
    drv1(1'b1, 16'hE0FF, 1'b1);
    look();
    chk("wrap_pre", DW'(p1_cnt), DW'(16'hFFFF));
    cyc(); look();
    chk("wrap_grant", DW'(grant), DW'(2'b10));
    cyc();
    drv1(1'b0, 16'h0, 1'b0);
    look();
    chk("wrap_p1cnt", DW'(p1_cnt), DW'(16'h0000));

    // asynchronous reset in the middle of a granted packet
    cyc();
    drv0(1'b1, 16'h9001, 1'b0);
    cyc();
    #2;
    chk("abort_pre_grant", DW'(grant), DW'(2'b01));
    rst = 1'b0;
    #1;
    chk("abort_grant", DW'(grant), DW'(2'b00));
    chk("abort_mvalid", DW'(m_tvalid), DW'(1'b0));
    chk("abort_s0rdy", DW'(s0_tready), DW'(1'b0));
    chk("abort_p0cnt", DW'(p0_cnt), DW'(16'd0));
    look();
    drv0(1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    cyc(); look();
    chk("abort_after_grant", DW'(grant), DW'(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcie_rq_arbiter.md
# pcie_rq_arbiter

Packet-level two-input arbiter that shares the PCIe Requester Request (RQ) AXI-stream between the user request path (port 0) and the ATS invalidation-completion generator (port 1). It sits directly in front of the PCIe core RQ interface. It never splits a TLP: a grant is held until the granted port's `tlast` beat completes. Port 1 has priority, with a starvation guard for port 0.

## Interface
- `AXIS_DATA_WIDTH`, 512: tdata width; tkeep is `AXIS_DATA_WIDTH/8`.
- `RQ_AXIS_TUSER_W`, 183: RQ tuser width.
- `MAX_P1_BURST`, 4: maximum consecutive port-1 packets granted while port 0 waits (1..255).

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous and active-low.
- `s0_axis_tdata/tkeep/tuser/tlast/tvalid`  in  DATA/KEEP/TUSER/1/1  user RQ requests.
- `s0_axis_tready`  out  1  backpressure to port 0.
- `s1_axis_tdata/tkeep/tuser/tlast/tvalid`  in  DATA/KEEP/TUSER/1/1  ATS invalidation completions.
- `s1_axis_tready`  out  1  backpressure to port 1.
- `m_axis_tdata/tkeep/tuser/tlast/tvalid`  out  DATA/KEEP/TUSER/1/1  to PCIe RQ.
- `m_axis_tready`  in  1  from PCIe RQ.
- `grant`  out  2  one-hot current owner: bit0 = port 0, bit1 = port 1, 00 = idle.
- `p0_pkt_cnt`, `p1_pkt_cnt`  out  16 each  completed packets per port; wrap at 0xFFFF→0.

## Operation
- States: IDLE, GNT0, GNT1.
- IDLE decision, taken on the `s*_axis_tvalid` values seen in IDLE:
  - Neither valid: stay in IDLE.
  - Only one port valid: grant that port.
  - Both valid: grant port 1, unless `burst_cnt == MAX_P1_BURST`, in which case grant port 0.
- GNTx behaviour:
  - `m_axis_*` = `sx_axis_*` (combinational mux); `m_axis_tvalid` = `sx_axis_tvalid`.
  - `sx_axis_tready` = `m_axis_tready`; the other port's tready = 0.
- GNTx exits to IDLE on a beat with `m_axis_tvalid & m_axis_tready & m_axis_tlast`. The same edge increments `px_pkt_cnt`. No other exit exists.
- `burst_cnt` (8 bit) is updated when a port-1 packet completes:
  - If `s0_axis_tvalid` is 1 on that cycle, `burst_cnt` increments, saturating at `MAX_P1_BURST`.
  - If `s0_axis_tvalid` is 0, `burst_cnt` clears to 0.
- `burst_cnt` clears to 0 when a port-0 packet completes.
- In IDLE:
  - `m_axis_tvalid` = 0.
  - Both treadys = 0.
  - `m_axis_tdata/tkeep/tuser/tlast` = 0.
- A deasserted `tvalid` mid-packet on the granted port keeps the grant; bubbles pass through.
- Dropping `tvalid` before a handshake is a source protocol violation. Behaviour in that case is undefined but must not corrupt the grant.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release) forces:
  - state IDLE, `grant` = 00, `burst_cnt` = 0;
  - `p0_pkt_cnt` = `p1_pkt_cnt` = 0;
  - `m_axis_tvalid` = 0, both treadys = 0.
- Reset mid-packet aborts the packet immediately. There is no recovery of partial TLPs.
- Arbitration latency: 1 cycle. A `tvalid` first seen in IDLE at edge N gives `grant` and `m_axis_tvalid` from cycle N+1.
- Packet gap: exactly 1 IDLE cycle after each `tlast` handshake. Back-to-back single-beat TLPs therefore sustain 1 beat per 2 cycles.
- Data path adds zero cycles of latency; `tready` is combinational from `m_axis_tready`.
- The `grant` output and the state are registered.
- Counter increments become visible the cycle after the `tlast` handshake.

## Test plan
- Reset, then idle inputs → `grant` = 00, `m_axis_tvalid` = 0, both counters 0.
- Port 0 alone sends a 3-beat TLP with `m_axis_tready` = 1:
  - `grant` = 01 at cycle 1;
  - beats appear on cycles 1–3;
  - IDLE at cycle 4;
  - `p0_pkt_cnt` = 1.
- Both ports valid in IDLE, each sending single-beat TLPs, with `MAX_P1_BURST` = 4:
  - grant order is 1,1,1,1,0,1,1,1,1,0;
  - a port-0 beat is never interleaved inside a port-1 TLP, and vice versa.
- Port 0 mid-packet (beat 2 of 4) when port 1 asserts valid:
  - port 1 stays stalled (`s1_axis_tready` = 0) until port-0 `tlast`;
  - port 1 is granted after one IDLE cycle.
- `m_axis_tready` toggles 1,0,0,1 during a granted packet → every beat delivered exactly once, in order, and the `tlast` beat holds until accepted.
- Counter wrap and reset abort:
  - preload 0xFFFF port-1 completions, complete one more → `p1_pkt_cnt` = 0;
  - assert `rst` during a granted packet → `grant` = 00 and `m_axis_tvalid` = 0 without waiting for a `clk` edge.
